// File: rtl/alu_issuer.sv
// Command-issuing front end for the 64-bit ALU: accepts instructions, reads operands
// from a local register file, drives the ALU, writes back and presents the result.
module alu_issuer #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [4:0]    instr_cmd,
  input  logic [6:0]    instr_opm,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [63:0]   ext_data,
  output logic [4:0]    alu_cmd,
  output logic [6:0]    alu_opm,
  output logic [63:0]   alu_a,
  output logic [63:0]   alu_b,
  input  logic [63:0]   alu_out,
  input  logic [63:0]   alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic [AW-1:0] res_rd,
  output logic [63:0]   flags_q,
  output logic          busy
);

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 5;
  localparam int unsigned MW = 7;

  typedef enum logic [1:0] {IDLE, ISSUE, WB, RESP} state_t;

  state_t        state;
  logic [DW-1:0] rf [NREGS];
  logic [CW-1:0] cmd_q;
  logic [MW-1:0] opm_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;

  // Ready depends on rst_n directly so nothing is accepted while reset is held.
  assign instr_ready = (state == IDLE) & rst_n;
  assign busy        = (state != IDLE);

  // ALU inputs move only on the ISSUE edge so the ALU sees exactly one evaluation per instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      opm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_cmd   <= '0;
      alu_opm   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      flags_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ext_we) begin
            rf[ext_addr] <= ext_data;
          end
          if (instr_valid) begin
            cmd_q <= instr_cmd;
            opm_q <= instr_opm;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          alu_cmd <= cmd_q;
          alu_opm <= opm_q;
          alu_a   <= rf[rs1_q];
          alu_b   <= rf[rs2_q];
          state   <= WB;
        end
        WB: begin
          rf[rd_q]  <= alu_out;
          res_data  <= alu_out;
          res_rd    <= rd_q;
          flags_q   <= alu_flags;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a small behavioural ALU model on the alu_* ports.
module tb_alu_issuer;

  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    instr_cmd;
  logic [6:0]    instr_opm;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [63:0]   ext_data;
  logic [4:0]    alu_cmd;
  logic [6:0]    alu_opm;
  logic [63:0]   alu_a;
  logic [63:0]   alu_b;
  logic [63:0]   alu_out;
  logic [63:0]   alu_flags;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [AW-1:0] res_rd;
  logic [63:0]   flags_q;
  logic          busy;

  int checks;
  int errors;

  alu_issuer #(.NREGS(8), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_cmd(instr_cmd), .instr_opm(instr_opm),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .alu_cmd(alu_cmd), .alu_opm(alu_opm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .flags_q(flags_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 0 ZERO, 18 ADDM (a + sign-extended opm), 19 ADD, else XOR.
  // Flags: bit 11 = zero result, bit 0 = negative result.
  always_comb begin
    case (alu_cmd)
      5'd0:    alu_out = 64'd0;
      5'd18:   alu_out = alu_a + {{57{alu_opm[6]}}, alu_opm};
      5'd19:   alu_out = alu_a + alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
    alu_flags = {52'd0, (alu_out == 64'd0), 10'd0, alu_out[63]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_load(input logic [AW-1:0] a, input logic [63:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic issue(input logic [4:0] c, input logic [6:0] m,
                       input logic [AW-1:0] rd, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    instr_valid = 1'b1; instr_cmd = c; instr_opm = m;
    instr_rd = rd; instr_rs1 = s1; instr_rs2 = s2;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({alu_cmd, alu_opm, alu_a, alu_b} !== '0) begin errors++; $display("FAIL rst_alu got %h %h %h %h exp 0", alu_cmd, alu_opm, alu_a, alu_b); end
    checks++; if ({res_data, res_rd, flags_q} !== '0) begin errors++; $display("FAIL rst_res got %h %h %h exp 0", res_data, res_rd, flags_q); end
    #3 rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", instr_ready); end
  endtask

  task automatic test_add();
    ext_load(3'd1, 64'd10);
    ext_load(3'd2, 64'hFFFF_FFFF_FFFF_FFF1);
    res_ready = 1'b1;
    issue(5'd19, 7'd0, 3'd3, 3'd1, 3'd2);
    checks++; if (instr_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_busy got ready=%b busy=%b exp 0/1", instr_ready, busy); end
    tick();
    checks++; if (alu_a !== 64'd10 || alu_b !== 64'hFFFF_FFFF_FFFF_FFF1 || alu_cmd !== 5'd19) begin
      errors++; $display("FAIL add_operands got a=%h b=%h cmd=%0d exp a=a b=fff1 cmd=19", alu_a, alu_b, alu_cmd); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFB || res_rd !== 3'd3) begin
      errors++; $display("FAIL add_result got v=%b d=%h rd=%0d exp 1 fffffffffffffffb 3", res_valid, res_data, res_rd); end
    checks++; if (dut.rf[3] !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL add_wb got %h exp fffffffffffffffb", dut.rf[3]); end
    checks++; if (flags_q !== 64'h1) begin errors++; $display("FAIL add_flags got %h exp 1", flags_q); end
    tick();
    checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL add_accept got v=%b ready=%b exp 0/1", res_valid, instr_ready); end
  endtask

  task automatic test_addm();
    ext_load(3'd1, 64'd5);
    issue(5'd18, 7'h7E, 3'd4, 3'd1, 3'd1);
    tick();
    tick();
    checks++; if (res_data !== 64'd3 || res_rd !== 3'd4) begin errors++; $display("FAIL addm_result got d=%h rd=%0d exp 3 4", res_data, res_rd); end
    checks++; if (flags_q[11] !== 1'b0) begin errors++; $display("FAIL addm_zflag got %b exp 0", flags_q[11]); end
    checks++; if (dut.rf[4] !== 64'd3) begin errors++; $display("FAIL addm_wb got %h exp 3", dut.rf[4]); end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    issue(5'd19, 7'd0, 3'd6, 3'd3, 3'd4);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFE || flags_q !== 64'h1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h f=%h exp 1 fffffffffffffffe 1", i, res_valid, res_data, flags_q); end
      checks++; if (instr_ready !== 1'b0 || alu_a !== 64'hFFFF_FFFF_FFFF_FFFB || alu_b !== 64'd3 || alu_cmd !== 5'd19) begin
        errors++; $display("FAIL bp_alu[%0d] got ready=%b a=%h b=%h cmd=%0d exp 0 fffffffffffffffb 3 19", i, instr_ready, alu_a, alu_b, alu_cmd); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b ready=%b exp 0/1", res_valid, instr_ready); end
  endtask

  task automatic test_ext_busy();
    res_ready = 1'b0;
    issue(5'd19, 7'd0, 3'd7, 3'd2, 3'd2);
    ext_we = 1'b1; ext_addr = 3'd1; ext_data = 64'hDEAD;
    tick(); tick(); tick();
    ext_we = 1'b0;
    checks++; if (dut.rf[1] !== 64'd5) begin errors++; $display("FAIL ext_busy got %h exp 5", dut.rf[1]); end
    checks++; if (dut.rf[7] !== 64'hFFFF_FFFF_FFFF_FFE2) begin errors++; $display("FAIL ext_busy_wb got %h exp ffffffffffffffe2", dut.rf[7]); end
    res_ready = 1'b1;
    tick();
    ext_we = 1'b1; ext_addr = 3'd1; ext_data = 64'hDEAD;
    issue(5'd19, 7'd0, 3'd5, 3'd1, 3'd0);
    ext_we = 1'b0;
    checks++; if (dut.rf[1] !== 64'hDEAD) begin errors++; $display("FAIL ext_idle got %h exp dead", dut.rf[1]); end
    tick();
    checks++; if (alu_a !== 64'hDEAD || alu_b !== 64'd0) begin errors++; $display("FAIL ext_same_cycle got a=%h b=%h exp dead 0", alu_a, alu_b); end
    tick();
    checks++; if (res_data !== 64'hDEAD) begin errors++; $display("FAIL ext_same_result got %h exp dead", res_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    ext_load(3'd5, 64'd7);
    issue(5'd0, 7'd0, 3'd5, 3'd1, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({alu_cmd, alu_opm, alu_a, alu_b} !== '0) begin errors++; $display("FAIL midrst_alu got %h %h %h %h exp 0", alu_cmd, alu_opm, alu_a, alu_b); end
    checks++; if ({res_valid, res_data, res_rd, flags_q, instr_ready, busy} !== '0) begin
      errors++; $display("FAIL midrst_outs got v=%b d=%h rd=%0d f=%h r=%b b=%b exp 0", res_valid, res_data, res_rd, flags_q, instr_ready, busy); end
    checks++; if (dut.rf[5] !== 64'd0) begin errors++; $display("FAIL midrst_rf got %h exp 0", dut.rf[5]); end
    #3 rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", instr_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet[%0d] got v=%b busy=%b exp 0/0", i, res_valid, busy); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] cmds [4];
    logic [4:0] prev_cmd;
    int n_acc;
    int n_chg;
    int acc_tick [4];
    cmds[0] = 5'd19; cmds[1] = 5'd18; cmds[2] = 5'd19; cmds[3] = 5'd18;
    n_acc = 0; n_chg = 0;
    prev_cmd = alu_cmd;
    res_ready = 1'b1;
    instr_valid = 1'b1;
    instr_opm = 7'd1; instr_rd = 3'd2; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    for (int t = 1; t <= 16; t++) begin
      logic acc;
      instr_cmd = (n_acc < 4) ? cmds[n_acc] : 5'd19;
      acc = instr_valid & instr_ready;
      tick();
      if (acc && n_acc < 4) begin acc_tick[n_acc] = t; n_acc++; end
      if (alu_cmd !== prev_cmd) n_chg++;
      prev_cmd = alu_cmd;
    end
    instr_valid = 1'b0;
    checks++; if (n_acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", n_acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i < n_acc && acc_tick[i] !== 1 + 4 * i) begin errors++; $display("FAIL b2b_period[%0d] got %0d exp %0d", i, acc_tick[i], 1 + 4 * i); end
    end
    checks++; if (n_chg !== 4) begin errors++; $display("FAIL b2b_alu_toggles got %0d exp 4", n_chg); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr_cmd = '0; instr_opm = '0;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; res_ready = 1'b0;
    test_reset();
    test_add();
    test_addm();
    test_backpressure();
    test_ext_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Command-issuing front end for the 64-bit ALU. It accepts instruction words over a valid/ready handshake and reads operands from a local register file.
- It drives the ALU's cmd/opm/a/b inputs, captures the ALU result and flags, writes the result back, and presents it on a backpressured result port.
- It sits between the decode/control path and the ALU, which it instantiates externally through its alu_* ports.

Parameters:
- NREGS, 8, number of 64-bit general registers (power of two, 2..32).
- AW, 3, register address width, equal to log2(NREGS).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  issuer can accept an instruction.
- instr_cmd  input  5  ALU command code.
- instr_opm  input  7  ALU operation-mode field.
- instr_rd  input  AW  destination register.
- instr_rs1  input  AW  source register for ALU a.
- instr_rs2  input  AW  source register for ALU b.
- ext_we  input  1  external register-load strobe.
- ext_addr  input  AW  external load address.
- ext_data  input  64  external load data.
- alu_cmd  output  5  to ALU cmd.
- alu_opm  output  7  to ALU opm.
- alu_a  output  64  to ALU a.
- alu_b  output  64  to ALU b.
- alu_out  input  64  from ALU out.
- alu_flags  input  64  from ALU flags output.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  64  captured ALU result.
- res_rd  output  AW  destination of res_data.
- flags_q  output  64  flags captured with the last result.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers = 0.
  - alu_cmd, alu_opm, alu_a, alu_b = 0.
  - res_valid = 0, res_data = 0, res_rd = 0, flags_q = 0.
  - instr_ready forced 0 while rst_n is low.
  - Reset mid-operation abandons the instruction; no write-back occurs.
- FSM states: IDLE, ISSUE, WB, RESP.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready at edge T: latch cmd/opm/rd/rs1/rs2 and go to ISSUE.
  - ext_we is honoured only in IDLE: rf[ext_addr] <= ext_data. In any other state ext_we is ignored.
  - If ext_we and an instruction handshake coincide, both take effect. Operands are read in ISSUE, so the loaded value is visible to that instruction.
- ISSUE (cycle T+1):
  - Register alu_cmd/alu_opm from the latched fields.
  - Register alu_a = rf[rs1] and alu_b = rf[rs2].
  - Go to WB.
- WB (cycle T+2): ALU inputs have been stable one full cycle. At the closing edge:
  - rf[rd] <= alu_out;
  - res_data <= alu_out; res_rd <= rd;
  - flags_q <= alu_flags;
  - res_valid <= 1; go to RESP.
- RESP:
  - res_valid = 1; res_data/res_rd/flags_q are held stable.
  - On res_valid & res_ready: res_valid <= 0 and go to IDLE.
  - Minimum instruction period is 4 cycles.
- ALU input stability:
  - alu_cmd/opm/a/b change only at the ISSUE edge and are held in every other state, including IDLE.
  - Reason: the ALU carries internal flag state that updates on any input change, so the issuer must never generate extra ALU evaluations.
- Write-back:
  - Write-back always occurs, including for cmd 2 (PASSFLAG); there rf[rd] receives the masked flag word.
  - rd may equal rs1 or rs2. Operands were captured in ISSUE, so there is no hazard.
- Register file:
  - rf has no hardwired-zero register.
  - Reads are combinational from rf; writes happen at most once per cycle (ext write in IDLE, WB write in WB), so writes never collide.
- busy = (state != IDLE).
- instr_ready = (state == IDLE) & rst_n.
- instr_valid may drop without being accepted; there is no side effect.

Test Plan:
- ext-load r1=10, r2=-15; issue cmd=19 (ADD) rd=3 rs1=1 rs2=2 accepted at T, res_ready=1 -> at T+1 alu_a=10, alu_b=0xFFFFFFFFFFFFFFF1; res_valid rises after the T+2 edge; res_data=0xFFFFFFFFFFFFFFFB, res_rd=3; rf[3] equals that value.
- r1=5, cmd=18 (ADDM) opm=7'h7E rd=4 -> res_data=3, flags_q bit11 (Z)=0, rf[4]=3.
- Backpressure:
  - Stimulus: res_ready=0 for 6 cycles after res_valid.
  - Required: res_valid stays 1; res_data/flags_q are unchanged; instr_ready=0; alu_* are unchanged; the result is accepted on the first res_ready=1 cycle, after which instr_ready=1 the next cycle.
- ext_we to r1 with 0xDEAD while busy -> rf[1] unchanged. The same write in IDLE updates rf[1] to 0xDEAD; the same-cycle instruction with rs1=1 reads 0xDEAD.
- Assert rst_n=0 during ISSUE of cmd=0 (ZERO) rd=5 with rf[5]=7 (pre-loaded) -> all outputs 0 immediately, rf[5]=0; after release instr_ready=1 and no res_valid appears.
- Back-to-back instructions with instr_valid held high and res_ready=1 -> one acceptance every 4 cycles; alu_cmd toggles exactly once per instruction.
